serial_adder: RTL and testbench

Bit-serial, multi-cycle adder that sequences the team's single-bit `half_adder` datapath to add two WIDTH-bit operands, LSB first, one bit per clock.
- Internally, two `half_adder` instances plus an OR gate form one full-adder cell; this block owns the operand shift registers, carry flop and control FSM around that cell.
- It sits between an upstream producer and a downstream consumer, both using valid/ready handshakes.
- It is intended as the area-minimal arithmetic option where latency is not critical.

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell built from two half adders,
// wrapped with operand shift registers, a carry flop and a handshake FSM.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic s0, c0, s1, c1, fa_cout;

    half_adder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0),      .b(carry),   .s(s1), .c(c1));
    assign fa_cout = c0 | c1;

    // in_ready/busy/out_valid are registered alongside the state so no
    // input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= 1'b0;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    res   <= {s1, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = res;
    assign cout = carry;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       in_ready8, out_valid8, cout8, busy8;
    logic [7:0] sum8;
    logic       in_ready2, out_valid2, cout2, busy2;
    logic [1:0] sum2;

    logic       in_ready, out_valid, cout, busy;
    logic [7:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(in_ready8),
        .a(a), .b(b),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(in_ready2),
        .a(a[1:0]), .b(b[1:0]),
        .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    assign in_ready  = sel ? in_ready2  : in_ready8;
    assign out_valid = sel ? out_valid2 : out_valid8;
    assign cout      = sel ? cout2      : cout8;
    assign busy      = sel ? busy2      : busy8;
    assign sum       = sel ? {6'b0, sum2} : sum8;

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] av, input logic [7:0] bv);
        chk("start_in_ready", in_ready, 1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_in_ready", in_ready, 0);
    endtask

    task automatic wait_res(input bit tog, output int cnt, output int bc);
        cnt = 0;
        bc = 0;
        while (!out_valid && cnt < 100) begin
            if (busy) bc++;
            if (tog) begin
                chk("busy_in_ready", in_ready, 0);
                in_valid = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("take_out_valid", out_valid, 0);
        chk("take_in_ready", in_ready, 1);
    endtask

    task automatic stream(input int w);
        logic [64:0] q[$];
        logic [64:0] mask, av, bv, e;
        int sent = 0, got = 0, cyc = 0;
        mask = (65'd1 << w) - 1;
        while (got < 200 && cyc < 20000) begin
            out_ready = ($urandom % 4) != 0;
            if (out_valid && out_ready) begin
                chk("stream_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stream_result", (65'(cout) << w) | 65'(sum), e);
                end
                got++;
            end
            in_valid = 1'b0;
            if (sent < 200 && ($urandom % 3) != 0) begin
                av = 65'($urandom) & mask;
                bv = 65'($urandom) & mask;
                a = av[7:0];
                b = bv[7:0];
                in_valid = 1'b1;
                if (in_ready) begin
                    q.push_back(av + bv);
                    sent++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", got, 200);
        chk("stream_leftover", q.size(), 0);
    endtask

    initial begin
        int cnt, bc;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // basic add with latency and busy-length checks
        start(8'h35, 8'h4A);
        wait_res(0, cnt, bc);
        chk("basic_latency", cnt, 8);
        chk("basic_busy_cycles", bc, 8);
        chk("basic_sum", sum, 8'h7F);
        chk("basic_cout", cout, 0);
        take();

        start(8'hFF, 8'h01);
        wait_res(0, cnt, bc);
        chk("ripple1_sum", sum, 8'h00);
        chk("ripple1_cout", cout, 1);
        take();
        start(8'hFF, 8'hFF);
        wait_res(0, cnt, bc);
        chk("ripple2_sum", sum, 8'hFE);
        chk("ripple2_cout", cout, 1);

        // back-pressure with a competing request held on the input
        a = 8'h01;
        b = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, 8'hFE);
            chk("bp_cout", cout, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_busy", busy, 1);
        wait_res(0, cnt, bc);
        chk("bp_latency", cnt, 8);
        chk("bp_sum2", sum, 8'h02);
        chk("bp_cout2", cout, 0);
        take();

        // input toggling while busy must not disturb captured operands
        start(8'hA7, 8'h6C);
        wait_res(1, cnt, bc);
        chk("tog_latency", cnt, 8);
        chk("tog_sum", sum, 8'h13);
        chk("tog_cout", cout, 1);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("done_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        take();

        // asynchronous reset in the middle of an operation
        start(8'hC3, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        start(8'h10, 8'h20);
        wait_res(0, cnt, bc);
        chk("post_rst_sum", sum, 8'h30);
        chk("post_rst_cout", cout, 0);
        take();

        stream(8);
        sel = 1'b1;
        @(negedge clk);
        stream(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
